// File: rtl/try_fpa.sv
// -----------------------------------------------------------------------------
// try_fpa : IEEE-754 binary16 adder, o = a + b
//
// A single combinational align / add / normalise / round datapath feeds one
// output register. The latency is one cycle, and a new operand pair can be
// accepted on every cycle.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous, active-low reset
//   in_valid   in   1   a/b valid this cycle
//   a, b       in   16  binary16 operands
//   out_valid  out  1   o holds a fresh result
//   o          out  16  binary16 sum (holds its value while out_valid=0)
//
// Configuration macro
//   RNE_EN     defined   : round-to-nearest-even using guard/round/sticky
//              undefined : truncate (round toward zero)
//
// Subnormal inputs are treated as zero. Results that would be subnormal
// are flushed to a signed zero.
// -----------------------------------------------------------------------------
module try_fpa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] o
);

  localparam int DATA_W = 16;
  localparam int MAN_W  = 10;
  localparam int SIG_W  = MAN_W + 1;   // hidden bit + mantissa
  localparam int EXT_W  = SIG_W + 3;   // + guard, round, sticky

  localparam logic [DATA_W-1:0] QNAN = 16'h7E00;

  // Count leading zeros of the 14-bit extended significand.
  function automatic logic [3:0] lzc_ext(input logic [EXT_W-1:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'd0;
    found = 1'b0;
    for (int i = EXT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 4'd1;
      end
    end
    return n;
  endfunction

  // Right-align the smaller significand. Bits shifted past the LSB are
  // ORed into the sticky position. A distance of 14 or more leaves only the
  // sticky bit, because the significand is never zero.
  function automatic logic [EXT_W-1:0] align_sticky(input logic [SIG_W-1:0] sig,
                                                    input logic [4:0]       d);
    logic [EXT_W-1:0] ext;
    logic [EXT_W-1:0] lost;
    logic [EXT_W-1:0] r;
    ext = {sig, 3'b000};
    if (d >= 5'd14) begin
      r = {{(EXT_W-1){1'b0}}, 1'b1};
    end else begin
      lost = ext & ~({EXT_W{1'b1}} << d);
      r    = (ext >> d) | {{(EXT_W-1){1'b0}}, |lost};
    end
    return r;
  endfunction

  // Round a normalised significand (n[13] = 1) and pack it. A rounding carry
  // bumps the exponent before the overflow and underflow checks.
  function automatic logic [DATA_W-1:0] round_pack(input logic              sign,
                                                   input logic signed [7:0] e,
                                                   input logic [EXT_W-1:0]  n);
    logic [SIG_W:0]    sig_r;
    logic signed [7:0] e_r;
    logic              up;
    logic [DATA_W-1:0] r;
`ifdef RNE_EN
    up = n[2] & (n[1] | n[0] | n[3]);
`else
    logic grs_unused;
    grs_unused = |n[2:0];
    up = 1'b0;
`endif
    sig_r = {1'b0, n[EXT_W-1:3]} + {{SIG_W{1'b0}}, up};
    e_r   = sig_r[SIG_W] ? (e + 8'sd1) : e;
    if (e_r >= 8'sd31)
      r = {sign, 5'h1F, 10'h000};
    else if (e_r <= 8'sd0)
      r = {sign, 15'h0000};
    else
      r = {sign, e_r[4:0], sig_r[MAN_W-1:0]};
    return r;
  endfunction

  // ---- stage p0 : combinational add datapath ----
  logic              sa_p0, sb_p0;
  logic [4:0]        ea_p0, eb_p0;
  logic [9:0]        ma_p0, mb_p0;
  logic              a_nan_p0, b_nan_p0, a_inf_p0, b_inf_p0, a_zero_p0, b_zero_p0;
  logic              a_ge_p0;
  logic              sx_p0;
  logic [4:0]        ex_p0, ey_p0, d_p0;
  logic [SIG_W-1:0]  sigx_p0, sigy_p0;
  logic [EXT_W-1:0]  x_ext_p0, y_ext_p0, diff_p0, norm_add_p0, norm_sub_p0;
  logic [EXT_W:0]    sum_p0;
  logic [3:0]        lz_p0;
  logic signed [7:0] ex_s_p0, e_add_p0, e_sub_p0;
  logic [DATA_W-1:0] res_p0;

  always_comb begin
    sa_p0 = a[15];  ea_p0 = a[14:10];  ma_p0 = a[9:0];
    sb_p0 = b[15];  eb_p0 = b[14:10];  mb_p0 = b[9:0];

    a_nan_p0  = (ea_p0 == 5'h1F) && (ma_p0 != 10'h0);
    b_nan_p0  = (eb_p0 == 5'h1F) && (mb_p0 != 10'h0);
    a_inf_p0  = (ea_p0 == 5'h1F) && (ma_p0 == 10'h0);
    b_inf_p0  = (eb_p0 == 5'h1F) && (mb_p0 == 10'h0);
    a_zero_p0 = (ea_p0 == 5'h00);
    b_zero_p0 = (eb_p0 == 5'h00);

    // X is the operand with the larger magnitude.
    a_ge_p0 = {ea_p0, ma_p0} >= {eb_p0, mb_p0};
    sx_p0   = a_ge_p0 ? sa_p0 : sb_p0;
    ex_p0   = a_ge_p0 ? ea_p0 : eb_p0;
    ey_p0   = a_ge_p0 ? eb_p0 : ea_p0;
    sigx_p0 = a_ge_p0 ? {1'b1, ma_p0} : {1'b1, mb_p0};
    sigy_p0 = a_ge_p0 ? {1'b1, mb_p0} : {1'b1, ma_p0};
    d_p0    = ex_p0 - ey_p0;

    x_ext_p0 = {sigx_p0, 3'b000};
    y_ext_p0 = align_sticky(sigy_p0, d_p0);
    ex_s_p0  = $signed({3'b000, ex_p0});

    // Same-sign path: a carry-out causes a one-bit right shift that keeps sticky.
    sum_p0 = {1'b0, x_ext_p0} + {1'b0, y_ext_p0};
    if (sum_p0[EXT_W]) begin
      norm_add_p0 = sum_p0[EXT_W:1] | {{(EXT_W-1){1'b0}}, sum_p0[0]};
      e_add_p0    = ex_s_p0 + 8'sd1;
    end else begin
      norm_add_p0 = sum_p0[EXT_W-1:0];
      e_add_p0    = ex_s_p0;
    end

    // Opposite-sign path: X >= Y, so the difference is never negative.
    diff_p0     = x_ext_p0 - y_ext_p0;
    lz_p0       = lzc_ext(diff_p0);
    norm_sub_p0 = diff_p0 << lz_p0;
    e_sub_p0    = ex_s_p0 - $signed({4'b0000, lz_p0});

    res_p0 = 16'h0000;
    if (a_nan_p0 || b_nan_p0)
      res_p0 = QNAN;
    else if (a_inf_p0 && b_inf_p0 && (sa_p0 != sb_p0))
      res_p0 = QNAN;
    else if (a_inf_p0)
      res_p0 = a;
    else if (b_inf_p0)
      res_p0 = b;
    else if (a_zero_p0 && b_zero_p0)
      res_p0 = {sa_p0 & sb_p0, 15'h0000};
    else if (a_zero_p0)
      res_p0 = b;
    else if (b_zero_p0)
      res_p0 = a;
    else if (sa_p0 == sb_p0)
      res_p0 = round_pack(sx_p0, e_add_p0, norm_add_p0);
    else if (diff_p0 == '0)
      res_p0 = 16'h0000;
    else
      res_p0 = round_pack(sx_p0, e_sub_p0, norm_sub_p0);
  end

  // ---- stage p1 : output register ----
  logic              vld_p1;
  logic [DATA_W-1:0] o_p1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      o_p1   <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) o_p1 <= res_p0;
    end
  end

  assign out_valid = vld_p1;
  assign o         = o_p1;

endmodule

// File: tb/tb_try_fpa.sv
module tb_try_fpa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_o;
  logic        exp_v;

  try_fpa dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .o         (o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference model: the operands are converted to exact integers in units of
  // 2^-24, added exactly, and the sum is rounded back to binary16.
  function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
    logic   xs, ys, s;
    int     xe, ye, xm, ym, p, e, sh;
    longint vx, vy, v, mag, m;
    xs = x[15]; xe = int'(x[14:10]); xm = int'(x[9:0]);
    ys = y[15]; ye = int'(y[14:10]); ym = int'(y[9:0]);
    if ((xe == 31 && xm != 0) || (ye == 31 && ym != 0)) return 16'h7E00;
    if (xe == 31 && ye == 31) return (xs != ys) ? 16'h7E00 : x;
    if (xe == 31) return x;
    if (ye == 31) return y;
    if (xe == 0 && ye == 0) return {xs & ys, 15'h0000};
    if (xe == 0) return y;
    if (ye == 0) return x;
    vx = longint'(1024 + xm) << (xe - 1);
    vy = longint'(1024 + ym) << (ye - 1);
    if (xs) vx = -vx;
    if (ys) vy = -vy;
    v = vx + vy;
    if (v == 0) return 16'h0000;
    s   = (v < 0);
    mag = s ? -v : v;
    p = 0;
    for (int i = 0; i < 48; i++) if (mag[i]) p = i;
    e = p - 9;
    if (e <= 0) return {s, 15'h0000};
    sh = p - 10;
    m  = mag >> sh;
`ifdef RNE_EN
    begin
      longint rem, half;
      rem = mag - (m << sh);
      if (sh > 0) begin
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && m[0])) m++;
      end
      if (m == 2048) begin
        m = 1024;
        e++;
      end
    end
`endif
    if (e >= 31) return {s, 5'h1F, 10'h000};
    return {s, 5'(e), m[9:0]};
  endfunction

  // Drive one cycle, then check both outputs #1 after the rising edge.
  task automatic step(input string tag, input logic rn, input logic v,
                      input logic [15:0] xa, input logic [15:0] xb, input logic [15:0] want);
    rst_n = rn; in_valid = v; a = xa; b = xb;
    @(posedge clk);
    #1;
    if (!rn) begin
      exp_v = 1'b0;
      exp_o = 16'h0000;
    end else begin
      exp_v = v;
      if (v) exp_o = want;
    end
    chk({tag, ".vld"}, {15'h0, out_valid}, {15'h0, exp_v});
    chk(tag, o, exp_o);
  endtask

  function automatic logic [15:0] rand_op(input logic [15:0] ref_op);
    logic [15:0] r;
    int          k, e;
    r = 16'($urandom);
    k = int'($urandom_range(0, 11));
    if (k == 0) begin
      r[14:10] = 5'h1F;
      if ($urandom_range(0, 1) == 0) r[9:0] = 10'h000;
    end else if (k == 1) begin
      r[14:10] = 5'h00;
    end else if (k < 7) begin
      e = int'(ref_op[14:10]) + int'($urandom_range(0, 4)) - 2;
      if (e < 1)  e = 1;
      if (e > 30) e = 30;
      r[14:10] = e[4:0];
      if (k == 2) r[9:0] = ref_op[9:0];
    end else if (k == 7) begin
      r[14:10] = 5'd30;
    end
    return r;
  endfunction

  initial begin
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    exp_o = '0; exp_v = 1'b0;

    // Reset takes priority over a valid input on the same edge.
    step("rst0", 1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h4000);
    step("rst1", 1'b0, 1'b1, 16'h3C00, 16'h3C00, 16'h4000);

    // Directed vectors on back-to-back cycles.
    step("one_plus_one", 1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h4000);
    step("two_minus_half", 1'b1, 1'b1, 16'h4000, 16'hB800, 16'h3E00);
    step("cancel", 1'b1, 1'b1, 16'h3E00, 16'hBE00, 16'h0000);
`ifdef RNE_EN
    step("round_grs", 1'b1, 1'b1, 16'h2C4D, 16'h3DCC, 16'h3E11);
    step("round_carry", 1'b1, 1'b1, 16'h3BFF, 16'h0C00, 16'h3C00);
    step("round_ovf", 1'b1, 1'b1, 16'h7BFF, 16'h4C00, 16'h7C00);
`else
    step("round_grs", 1'b1, 1'b1, 16'h2C4D, 16'h3DCC, 16'h3E10);
    step("round_carry", 1'b1, 1'b1, 16'h3BFF, 16'h0C00, 16'h3BFF);
    step("round_ovf", 1'b1, 1'b1, 16'h7BFF, 16'h4C00, 16'h7BFF);
`endif
    step("overflow", 1'b1, 1'b1, 16'h7BFF, 16'h7BFF, 16'h7C00);
    step("neg_overflow", 1'b1, 1'b1, 16'hFBFF, 16'hFBFF, 16'hFC00);
    step("zero_plus_x", 1'b1, 1'b1, 16'h0000, 16'h3DCC, 16'h3DCC);
    step("inf_minus_inf", 1'b1, 1'b1, 16'h7C00, 16'hFC00, 16'h7E00);
    step("nan_in", 1'b1, 1'b1, 16'h7E01, 16'h3C00, 16'h7E00);
    step("x_plus_inf", 1'b1, 1'b1, 16'h3C00, 16'hFC00, 16'hFC00);
    step("negz_negz", 1'b1, 1'b1, 16'h8000, 16'h8000, 16'h8000);
    step("posz_negz", 1'b1, 1'b1, 16'h0000, 16'h8000, 16'h0000);
    step("subn_ftz", 1'b1, 1'b1, 16'h3BFF, 16'h0001, 16'h3BFF);
    step("underflow", 1'b1, 1'b1, 16'h8401, 16'h0400, 16'h8000);
    // Idle cycles: o holds its last value while out_valid is low.
    step("hold0", 1'b1, 1'b0, 16'h3C00, 16'h3C00, 16'h4000);
    step("hold1", 1'b1, 1'b0, 16'h1234, 16'h4321, 16'h0000);

    // Randomised traffic checked against the model.
    for (int i = 0; i < 3000; i++) begin
      ra = rand_op(16'($urandom));
      rb = rand_op(ra);
      if ($urandom_range(0, 1) == 0) rb[15] = ~ra[15];
      if (i == 1500) begin
        step("mid_rst", 1'b0, 1'b1, ra, rb, model_add(ra, rb));
        step("after_rst", 1'b1, 1'b1, 16'h3C00, 16'h3C00, 16'h4000);
      end else begin
        step("rand", 1'b1, ($urandom_range(0, 4) != 0), ra, rb, model_add(ra, rb));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
